// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports, the shared read result, and the data-memory port.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic [DATA_W-1:0] rdata;
    logic              grant;
    logic [ADDR_W-1:0] mem_read_address;
    logic [ADDR_W-1:0] mem_write_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_read_data,
        output r0_ack, r1_ack, rdata, grant,
        output mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_read_data,
        input  r0_ack, r1_ack, rdata, grant,
        input  mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory (IDLE -> ACCESS -> RESP).
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_enable,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_reg;
    logic              grant_reg;
    logic              we_reg;
    logic              mem_we_reg;
    logic              r0_ack_reg;
    logic              r1_ack_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic              any_req;
    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = bus.r0_req | bus.r1_req;

`ifdef ARB_ROUND_ROBIN_EN
    // last_reg = requester granted most recently; reset to 1 so requester 0 wins the first conflict
    logic last_reg;
    assign winner = (bus.r0_req && bus.r1_req) ? ~last_reg : ~bus.r0_req;
`else
    assign winner = ~bus.r0_req;
`endif

    assign sel_we    = winner ? bus.r1_we    : bus.r0_we;
    assign sel_addr  = winner ? bus.r1_addr  : bus.r0_addr;
    assign sel_wdata = winner ? bus.r1_wdata : bus.r0_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            grant_reg  <= 1'b0;
            we_reg     <= 1'b0;
            mem_we_reg <= 1'b0;
            r0_ack_reg <= 1'b0;
            r1_ack_reg <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_reg   <= 1'b1;
`endif
        end else if (clk_enable) begin
            r0_ack_reg <= 1'b0;
            r1_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        // memory-side outputs are loaded here so they are valid throughout ACCESS
                        grant_reg  <= winner;
                        we_reg     <= sel_we;
                        mem_we_reg <= sel_we;
                        addr_reg   <= sel_addr;
                        wdata_reg  <= sel_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_reg   <= winner;
`endif
                        state_reg  <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_reg <= 1'b0;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (grant_reg) begin
                        r1_ack_reg <= 1'b1;
                    end else begin
                        r0_ack_reg <= 1'b1;
                    end
                    if (!we_reg) begin
                        rdata_reg <= bus.mem_read_data;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    mem_we_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign bus.r0_ack            = r0_ack_reg;
    assign bus.r1_ack            = r1_ack_reg;
    assign bus.rdata             = rdata_reg;
    assign bus.grant             = grant_reg;
    assign bus.mem_read_address  = addr_reg;
    assign bus.mem_write_address = addr_reg;
    assign bus.mem_write_data    = wdata_reg;
    assign bus.mem_write_enable  = mem_we_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts ack order, read data and memory writes;
// independent monitors pop and compare whenever the DUT pulses an ack or a memory write.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        logic          who;
        logic [DW-1:0] data;
    } aexp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wexp_t;

    logic clk;
    logic rst_n;
    logic clk_enable;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    aexp_t         aq[$];
    wexp_t         wq[$];
    logic [DW-1:0] ref_mem [256];
    logic          last_served;
    logic [DW-1:0] last_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed_word(int i);
        if (i == 'h10) return 32'hDEADBEEF;
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0F0F;
    endfunction

    // External synchronous memory: one-cycle read latency, write on enable
    logic [DW-1:0] mem [256];
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (bus.mem_write_enable) mem[bus.mem_write_address] <= bus.mem_write_data;
            bus.mem_read_data <= mem[bus.mem_read_address];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: arbitration rule and memory semantics at transaction level
    function automatic logic pick(logic b0, logic b1);
        if (b0 && b1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return ~last_served;
`else
            return 1'b0;
`endif
        end
        return b0 ? 1'b0 : 1'b1;
    endfunction

    task automatic model_issue(input logic who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        aexp_t e;
        wexp_t w;
        if (we) begin
            ref_mem[a] = d;
            w.addr = a;
            w.data = d;
            wq.push_back(w);
        end else begin
            last_rdata = ref_mem[a];
        end
        e.who  = who;
        e.data = last_rdata;
        aq.push_back(e);
        last_served = who;
    endtask

    // Monitors
    bit en_edge = 1'b1;
    bit ack_prev = 1'b0;
    bit we_prev = 1'b0;
    int r1_ack_count = 0;
    always @(posedge clk) en_edge <= clk_enable;

    always @(negedge clk) begin
        automatic bit ack_now = bus.r0_ack | bus.r1_ack;
        automatic bit we_now  = bus.mem_write_enable;
        automatic aexp_t e;
        automatic wexp_t w;
        if (ack_now && !(ack_prev && !en_edge)) begin
            if (bus.r1_ack) r1_ack_count <= r1_ack_count + 1;
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got r0_ack=%b r1_ack=%b expected none", bus.r0_ack, bus.r1_ack);
            end else begin
                e = aq.pop_front();
                check("ack_pair", {31'd0, bus.r0_ack & bus.r1_ack}, 32'd0);
                check("ack_who", {31'd0, bus.r1_ack}, {31'd0, e.who});
                check("ack_grant", {31'd0, bus.grant}, {31'd0, e.who});
                check("ack_rdata", bus.rdata, e.data);
            end
        end
        if (we_now && !(we_prev && !en_edge)) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", bus.mem_write_address, bus.mem_write_data);
            end else begin
                w = wq.pop_front();
                check("write_addr", {24'd0, bus.mem_write_address}, {24'd0, w.addr});
                check("write_raddr", {24'd0, bus.mem_read_address}, {24'd0, w.addr});
                check("write_data", bus.mem_write_data, w.data);
            end
        end
        ack_prev <= ack_now;
        we_prev  <= we_now;
    end

    function automatic logic ack_of(logic who);
        return who ? bus.r1_ack : bus.r0_ack;
    endfunction

    task automatic set_req(input logic who, input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who) begin
            bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
        end else begin
            bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
        end
    endtask

    // Raise a request at a negedge, hold it until its ack is seen, then drop it
    task automatic drive(input logic who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_lat);
        int lat = 0;
        bit got = 1'b0;
        set_req(who, 1'b1, we, a, d);
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack_of(who)) got = 1'b1;
        end
        set_req(who, 1'b0, we, a, d);
        check(who ? "latency_r1" : "latency_r0", got ? 32'(lat) : 32'hFFFFFFFF, 32'(exp_lat));
    endtask

    task automatic do_txn(input logic who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        model_issue(who, we, a, d);
        drive(who, we, a, d, 3);
    endtask

    task automatic do_pair(input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic w;
        w = pick(1'b1, 1'b1);
        if (w) begin
            model_issue(1'b1, we1, a1, d1);
            model_issue(1'b0, we0, a0, d0);
        end else begin
            model_issue(1'b0, we0, a0, d0);
            model_issue(1'b1, we1, a1, d1);
        end
        fork
            drive(1'b0, we0, a0, d0, w ? 6 : 3);
            drive(1'b1, we1, a1, d1, w ? 3 : 6);
        join
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_r0_ack"}, {31'd0, bus.r0_ack}, 32'd0);
        check({tag, "_r1_ack"}, {31'd0, bus.r1_ack}, 32'd0);
        check({tag, "_rdata"}, bus.rdata, 32'd0);
        check({tag, "_grant"}, {31'd0, bus.grant}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, bus.mem_write_enable}, 32'd0);
        check({tag, "_raddr"}, {24'd0, bus.mem_read_address}, 32'd0);
        check({tag, "_waddr"}, {24'd0, bus.mem_write_address}, 32'd0);
        check({tag, "_wdata"}, bus.mem_write_data, 32'd0);
    endtask

    task automatic stall_txn(input logic who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        model_issue(who, we, a, d);
        set_req(who, 1'b1, we, a, d);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_resp_no_ack", {31'd0, ack_of(who)}, 32'd0);
        clk_enable = 1'b1;
        @(posedge clk); @(negedge clk);
        check("stall_ack_rise", {31'd0, ack_of(who)}, 32'd1);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_ack_held", {31'd0, ack_of(who)}, 32'd1);
        clk_enable = 1'b1;
        set_req(who, 1'b0, we, a, d);
        @(negedge clk);
        check("stall_ack_fall", {31'd0, ack_of(who)}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]    exp_seq;
        logic [3:0]    seen;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int            n;
        int            cyc;
        int            r1_before;

        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
        last_served = 1'b1;
        last_rdata  = '0;
        rst_n       = 1'b0;
        clk_enable  = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed single read and write/read-back
        do_txn(1'b0, 1'b0, 8'h10, '0);
        check("single_read", bus.rdata, 32'hDEADBEEF);
        do_txn(1'b1, 1'b1, 8'h22, 32'hCAFEF00D);
        do_txn(1'b0, 1'b0, 8'h22, '0);
        check("write_readback", bus.rdata, 32'hCAFEF00D);

        // Withdrawn request: r1 pulses during r0's ACCESS
        r1_before = r1_ack_count;
        model_issue(1'b0, 1'b0, 8'h33, '0);
        set_req(1'b0, 1'b1, 1'b0, 8'h33, '0);
        @(posedge clk); @(negedge clk);
        set_req(1'b1, 1'b1, 1'b1, 8'h34, 32'h11112222);
        @(posedge clk); @(negedge clk);
        bus.r1_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("withdraw_r0_ack", {31'd0, bus.r0_ack}, 32'd1);
        bus.r0_req = 1'b0;
        repeat (4) @(negedge clk);
        check("withdraw_no_r1_ack", 32'(r1_ack_count - r1_before), 32'd0);

        // Clock-enable stalls around RESP
        stall_txn(1'b1, 1'b1, 8'h40, 32'hA5A55A5A);
        stall_txn(1'b0, 1'b0, 8'h40, '0);

        // Randomized traffic, with occasional simultaneous requests
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_pair(1'($urandom), 8'($urandom_range(0, 'hEF)), $urandom,
                        1'($urandom), 8'($urandom_range(0, 'hEF)), $urandom);
            end else begin
                do_txn(1'($urandom), 1'($urandom), 8'($urandom_range(0, 'hEF)), $urandom);
            end
        end

        // Reset during ACCESS of a write: the write pulse has already been issued, the ack must never come
        d = $urandom;
        begin
            wexp_t w;
            w.addr = 8'hF0;
            w.data = d;
            wq.push_back(w);
        end
        set_req(1'b1, 1'b1, 1'b1, 8'hF0, d);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        bus.r1_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check_reset_outputs("abort");
        ref_mem[8'hF0] = d;
        last_served = 1'b1;
        last_rdata  = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_ack", {31'd0, bus.r1_ack}, 32'd0);
        d = $urandom;
        do_txn(1'b1, 1'b1, 8'hF0, d);
        do_txn(1'b0, 1'b0, 8'hF0, '0);
        check("abort_retry_readback", bus.rdata, d);

        // Sustained contention for four transactions, right after a fresh reset
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        last_served = 1'b1;
        last_rdata  = '0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a = pick(1'b1, 1'b1) ? 8'h51 : 8'h50;
            model_issue(pick(1'b1, 1'b1), 1'b0, a, '0);
        end
        set_req(1'b0, 1'b1, 1'b0, 8'h50, '0);
        set_req(1'b1, 1'b1, 1'b0, 8'h51, '0);
        n    = 0;
        cyc  = 0;
        seen = '0;
        while (n < 4 && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.r0_ack || bus.r1_ack) begin
                seen[n] = bus.r1_ack;
                n++;
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h50, '0);
        set_req(1'b1, 1'b0, 1'b0, 8'h51, '0);
        check("contention_count", 32'(n), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) check("contention_grant", {31'd0, seen[k]}, {31'd0, exp_seq[k]});

        repeat (6) @(negedge clk);
        check("pending_acks", 32'(aq.size()), 32'd0);
        check("pending_writes", 32'(wq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port clk_enable  input  1  when low, all registers hold their value.
REQ-006 SHALL have ports r0_req / r1_req  input  1  per-requester access request.
REQ-007 SHALL have ports r0_we / r1_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports r0_addr / r1_addr  input  ADDR_W  word address.
REQ-009 SHALL have ports r0_wdata / r1_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports r0_ack / r1_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  DATA_W  read result, shared by both requesters, valid while the matching ack is high.
REQ-012 SHALL have ports mem_read_address / mem_write_address  output  ADDR_W  to data memory.
REQ-013 SHALL have ports mem_write_data  output  DATA_W and mem_write_enable  output  1  to data memory.
REQ-014 SHALL have port mem_read_data  input  DATA_W  from data memory; valid one cycle after the address is presented.
REQ-015 SHALL have port grant  output  1  index of the requester owning the current transaction.

Function
REQ-016 SHALL implement states IDLE, ACCESS, RESP; all outputs registered.
REQ-017 IDLE: if any req is high, latch the winner's we/addr/wdata, set grant, go to ACCESS; otherwise stay in IDLE.
REQ-018 ACCESS: drive the latched address on both mem address ports; mem_write_enable equals the latched we for exactly this cycle; go to RESP.
REQ-019 RESP: pulse the granted ack for one cycle; on a read, rdata = mem_read_data; on a write, rdata holds its previous value; go to IDLE.
REQ-020 Latency: req sampled high in IDLE at edge N gives ack high in the cycle following edge N+2; throughput is one transaction per 3 cycles.
REQ-021 A requester SHALL hold req/we/addr/wdata stable until its ack; the arbiter samples them only in IDLE.
REQ-022 When both req are high in IDLE, arbitration follows REQ-031/REQ-032.
REQ-023 A req still high in the IDLE cycle after its ack counts as a new request.
REQ-024 A req that drops before it is granted is discarded; no memory access is made for it.
REQ-025 Address passes through unmodified; there is no wrap or range check.
REQ-026 When clk_enable is low, state, FSM and pulses freeze; an ack held over a frozen cycle remains high until the next enabled edge.

Reset
REQ-027 When rst_n is low at an enabled or disabled edge, the FSM goes to IDLE and r0_ack=0, r1_ack=0, rdata=0, grant=0, mem_write_enable=0, both mem addresses=0, mem_write_data=0, and the round-robin pointer is set so requester 0 wins first.
REQ-028 Reset has priority over clk_enable.
REQ-029 Reset during ACCESS or RESP SHALL abort the transaction: no ack is issued and mem_write_enable is low from the reset edge onward.
REQ-030 The aborted requester SHALL re-request after reset.

Configuration
REQ-031 With ARB_ROUND_ROBIN_EN defined, a conflict SHALL be granted to the requester not served last; the last-served pointer updates on each grant.
REQ-032 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win a conflict (fixed priority), and the pointer logic is absent.

Verification
REQ-033 Single read: mem[0x10]=0xDEADBEEF; r0 reads 0x10 -> r0_ack pulse with rdata=0xDEADBEEF, 3 cycles after req is sampled.
REQ-034 Single write: r1 writes 0xCAFEF00D to 0x22 -> one-cycle mem_write_enable with address 0x22; a later r0 read of 0x22 returns 0xCAFEF00D.
REQ-035 Contention: both hold req continuously for 4 transactions -> grants 0,1,0,1 with ARB_ROUND_ROBIN_EN, and 0,0,0,0 without it.
REQ-036 Reset mid-write: rst_n low during ACCESS -> no ack issued, mem_write_enable=0 from the reset edge, all outputs at reset values.
REQ-037 Stall: clk_enable low for 5 cycles during RESP -> ack stays high and the transaction resumes without a duplicate ack or write.
REQ-038 Withdrawn request: r1_req pulses for one cycle while r0 is in ACCESS -> no r1 transaction and no r1_ack.
